// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//   Round-robin arbiter sharing the board's 32-bit hex display register among
//   NREQ requesters. An owner keeps the display for at least HOLD_CYCLES and is
//   preempted only when another requester is waiting. Back-to-back grants to
//   different requesters always see at least one all-zero grant cycle.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   req_i       level request per requester (bit i = requester i)
//   req_data_i  display word per requester, slice i = [i*DW +: DW]
//   gnt_o       registered one-hot grant, zero when nobody owns the display
//   owner_o     index of the current or most recent owner
//   busy_o      high while an owner holds the display
//   disp_o      registered display word to the 7-segment drivers
//
// Build option
//   HEX_ARB_BLANK_IDLE_EN : when defined, disp_o resets to all-ones and is
//   blanked to all-ones whenever ownership ends (release or preemption).
//   When undefined, disp_o resets to zero and holds the last owner's word.

module hex_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 32,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [2:0]         owner_o,
  output logic               busy_o,
  output logic [DW-1:0]      disp_o
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

`ifdef HEX_ARB_BLANK_IDLE_EN
  localparam logic [DW-1:0] DISP_RST = '1;
`else
  localparam logic [DW-1:0] DISP_RST = '0;
`endif

  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

  state_t            state, state_nxt;
  logic [2:0]        rr_ptr, rr_nxt;
  logic [CW-1:0]     hold_cnt, cnt_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [2:0]        owner_nxt;
  logic              busy_nxt;
  logic [DW-1:0]     disp_nxt;

  logic [2:0]        pick;
  logic              pick_valid;
  logic              owner_req;
  logic              others_req;
  logic              hold_done;
  logic [2:0]        ptr_after_owner;
  logic [DW-1:0]     owner_data;
  logic [NREQ-1:0]   owner_mask;
  logic [NREQ*DW-1:0] data_shift;
  logic [NREQ-1:0]   req_shift;

  // Rotating priority search: scan downwards so the lowest offset from
  // rr_ptr is the last assignment and therefore the winner.
  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    req_shift  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      req_shift = req_i >> ((int'(rr_ptr) + k) % NREQ);
      if (req_shift[0]) begin
        pick       = 3'((int'(rr_ptr) + k) % NREQ);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owner_mask      = {{(NREQ-1){1'b0}}, 1'b1} << owner_o;
    owner_req       = |(req_i & owner_mask);
    others_req      = |(req_i & ~owner_mask);
    hold_done       = (hold_cnt == CW'(HOLD_CYCLES));
    ptr_after_owner = (owner_o == 3'(NREQ - 1)) ? 3'd0 : owner_o + 3'd1;
    data_shift      = req_data_i >> (DW * int'(owner_o));
    owner_data      = data_shift[DW-1:0];
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_o;
    owner_nxt = owner_o;
    busy_nxt  = busy_o;
    rr_nxt    = rr_ptr;
    cnt_nxt   = hold_cnt;
    disp_nxt  = disp_o;
    case (state)
      IDLE, SWITCH: begin
        if (pick_valid) begin
          state_nxt = OWN;
          gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          owner_nxt = pick;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          // SWITCH never lasts more than one cycle.
          state_nxt = IDLE;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release takes priority over a simultaneous preemption.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = ptr_after_owner;
`ifdef HEX_ARB_BLANK_IDLE_EN
          disp_nxt  = '1;
`endif
        end else if (hold_done && others_req) begin
          state_nxt = SWITCH;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = ptr_after_owner;
`ifdef HEX_ARB_BLANK_IDLE_EN
          disp_nxt  = '1;
`else
          disp_nxt  = owner_data;
`endif
        end else begin
          disp_nxt = owner_data;
          if (!hold_done) cnt_nxt = hold_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt_o    <= '0;
      owner_o  <= '0;
      busy_o   <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      disp_o   <= DISP_RST;
    end else begin
      state    <= state_nxt;
      gnt_o    <= gnt_nxt;
      owner_o  <= owner_nxt;
      busy_o   <= busy_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= cnt_nxt;
      disp_o   <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed testbench for hex_display_arbiter (NREQ=4, DW=32, HOLD_CYCLES=8).
// Honours HEX_ARB_BLANK_IDLE_EN for the expected display values.

module tb_hex_display_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int HOLD = 8;

`ifdef HEX_ARB_BLANK_IDLE_EN
  localparam logic [31:0] DISP_RST = 32'hFFFF_FFFF;
  localparam bit          BLANK    = 1'b1;
`else
  localparam logic [31:0] DISP_RST = 32'h0000_0000;
  localparam bit          BLANK    = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         owner;
  logic               busy;
  logic [DW-1:0]      disp;

  int n_chk  = 0;
  int n_fail = 0;

  hex_display_arbiter #(
    .NREQ(NREQ), .DW(DW), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (req),
    .req_data_i (req_data),
    .gnt_o      (gnt),
    .owner_o    (owner),
    .busy_o     (busy),
    .disp_o     (disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    req_data = '0;
    do_reset();

    // Reset state
    chk("rst_gnt",   gnt,   4'b0000);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_owner", owner, 3'd0);
    chk("rst_disp",  disp,  DISP_RST);

    // Single requester 2: grant after one edge, display after two
    req_data[2*DW +: DW] = 32'h1234_5678;
    req = 4'b0100;
    step();
    chk("t1_gnt",   gnt,   4'b0100);
    chk("t1_owner", owner, 3'd2);
    chk("t1_busy",  busy,  1'b1);
    step();
    chk("t1_disp",  disp,  32'h1234_5678);
    req_data[2*DW +: DW] = 32'hCAFE_F00D;
    step();
    chk("t1_track", disp,  32'hCAFE_F00D);
    req = 4'b0000;
    step();
    chk("t1_rel_gnt",   gnt,   4'b0000);
    chk("t1_rel_busy",  busy,  1'b0);
    chk("t1_rel_owner", owner, 3'd2);
    chk("t1_rel_disp",  disp,  BLANK ? 32'hFFFF_FFFF : 32'hCAFE_F00D);
    step();
    chk("t1_idle_disp", disp,  BLANK ? 32'hFFFF_FFFF : 32'hCAFE_F00D);

    // Round-robin order 0, 1, 3, 0 from reset
    do_reset();
    req = 4'b1011;
    step();
    chk("t2_g0", gnt, 4'b0001);
    req = 4'b1010;
    step();
    chk("t2_gap0", gnt, 4'b0000);
    step();
    chk("t2_g1", gnt, 4'b0010);
    chk("t2_o1", owner, 3'd1);
    req = 4'b1000;
    step();
    chk("t2_gap1", gnt, 4'b0000);
    chk("t2_o_hold", owner, 3'd1);
    step();
    chk("t2_g3", gnt, 4'b1000);
    chk("t2_o3", owner, 3'd3);
    req = 4'b0001;
    step();
    chk("t2_gap3", gnt, 4'b0000);
    step();
    chk("t2_g0b", gnt, 4'b0001);
    req = 4'b0000;
    step();
    chk("t2_end", gnt, 4'b0000);

    // Preemption: owner 1 holds, requester 3 arrives at grant+2
    do_reset();
    req_data[1*DW +: DW] = 32'hA1A1_A1A1;
    req_data[3*DW +: DW] = 32'h3333_3333;
    req = 4'b0010;
    step();                               // edge G
    chk("t3_g1", gnt, 4'b0010);
    step();
    step();                               // G+2
    req = 4'b1010;
    for (int k = 3; k <= HOLD; k++) step(); // through G+HOLD
    chk("t3_still_g1", gnt, 4'b0010);
    step();                               // G+HOLD+1
    chk("t3_drop",   gnt,   4'b0000);
    chk("t3_owner",  owner, 3'd1);
    chk("t3_disp",   disp,  BLANK ? 32'hFFFF_FFFF : 32'hA1A1_A1A1);
    step();                               // G+HOLD+2
    chk("t3_g3",     gnt,   4'b1000);
    chk("t3_owner3", owner, 3'd3);
    chk("t3_busy",   busy,  1'b1);
    step();
    chk("t3_disp3",  disp,  32'h3333_3333);
    req = 4'b0010;
    step();
    chk("t3_rel3", gnt, 4'b0000);
    step();
    chk("t3_regrant1", gnt, 4'b0010);

    // Owner drops exactly when preemption would fire: release path wins
    do_reset();
    req = 4'b0010;
    step();                               // edge G
    chk("t4_g1", gnt, 4'b0010);
    req = 4'b0111;
    for (int k = 1; k <= HOLD; k++) step(); // through G+HOLD
    chk("t4_pre", gnt, 4'b0010);
    req = 4'b0101;
    step();                               // G+HOLD+1
    chk("t4_drop_gnt",  gnt,  4'b0000);
    chk("t4_drop_busy", busy, 1'b0);
    step();
    chk("t4_g2",     gnt,   4'b0100);
    chk("t4_owner2", owner, 3'd2);

    // Asynchronous reset mid-ownership, between clock edges
    reset_n = 1'b0;
    #1;
    chk("t5_gnt",   gnt,   4'b0000);
    chk("t5_busy",  busy,  1'b0);
    chk("t5_owner", owner, 3'd0);
    chk("t5_disp",  disp,  DISP_RST);
    step();
    req = 4'b1001;
    reset_n = 1'b1;
    step();
    chk("t5_g0", gnt, 4'b0001);
    req = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
